cayde_muldiv: RTL and testbench
===============================

# cayde_muldiv

Parametrised iterative multiply/divide unit implementing the RV32M operation set for the cayde RISC-V core. It sits beside the single-cycle integer ALU in the execute stage and takes the same operand pair. Unlike the ALU, it runs one shift-add or shift-subtract step per clock and returns results through a valid/ready handshake. Divide-by-zero and signed overflow resolve on a fast path.

## Interface
- XLEN, default 32: operand and result width; any value ≥ 4.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  reset, synchronous and active-low.
- valid_i  in  1  request valid.
- ready_o  out  1  unit can accept a request.
- op_i  in  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a  in  XLEN  operand rs1 (dividend / multiplicand).
- op_b  in  XLEN  operand rs2 (divisor / multiplier).
- kill_i  in  1  flush: abort any in-flight operation.
- valid_o  out  1  result valid.
- ready_i  in  1  consumer accepts result.
- res_var  out  XLEN  result.

## Operation
- States: IDLE, CALC, FIX, DONE.
- Reset (rst_ni low at an edge): state IDLE, ready_o=1, valid_o=0, res_var=0, iteration counter=0.
- IDLE: ready_o=1. On valid_i && !kill_i, latch op_i, op_a, op_b and record operand signs:
  - signed for MULH/DIV/REM (both operands);
  - signed for MULHSU (op_a only);
  - unsigned otherwise.
  - Store operand magnitudes (absolute value of signed-negative operands).
- Fast path, checked at accept:
  - DIV/DIVU/REM/REMU with op_b==0 → DONE directly. Quotient = all ones; remainder = op_a.
  - DIV/REM with op_a==1<<(XLEN-1) and op_b==all ones → DONE directly. Quotient = op_a; remainder = 0.
  - Otherwise → CALC, counter=0.
- CALC, multiply: 2·XLEN-bit product accumulator, one step per cycle. Step: add multiplicand if the current multiplier LSB is set, then shift.
- CALC, divide: restoring division, one quotient bit per cycle. Partial remainder is XLEN+1 bits wide.
- CALC runs exactly XLEN iterations. After iteration XLEN-1 → FIX.
- FIX: one cycle.
  - Negate the product if the operand signs differ.
  - Negate the quotient if the signs differ (DIV only).
  - Give the remainder the dividend's sign (REM only).
  - Select the result: MUL low XLEN bits; MULH/MULHSU/MULHU high XLEN bits; DIV/DIVU quotient; REM/REMU remainder.
  - Register res_var, then → DONE.
- DONE: valid_o=1 and res_var held stable until ready_i. On ready_i → IDLE. No new request is accepted in the same cycle.
- kill_i: in any state, the next edge goes to IDLE with valid_o=0. It overrides valid_i in IDLE and overrides ready_i in DONE. res_var keeps its last value.
- Arithmetic is modulo 2^XLEN. No exceptions or flags are raised.

## Timing
- Request handshake occurs when valid_i && ready_o are high at an edge. ready_o is low in CALC, FIX and DONE.
- Normal latency: valid_o first high XLEN+2 cycles after the accept edge (XLEN CALC cycles + 1 FIX cycle). This is 34 cycles for XLEN=32 and does not depend on the data.
- Fast-path latency: valid_o high in the cycle immediately after the accept edge.
- Result handshake: valid_o && ready_i. ready_o is high the cycle after the result handshake. Maximum throughput is one op per XLEN+3 cycles.
- valid_o, once raised, stays high until the handshake or kill_i. res_var must not change while valid_o is high.
- Mid-operation reset or kill: no partial result or valid_o pulse may appear afterwards.
- Inputs op_i/op_a/op_b are sampled only at accept. Later changes are ignored.

## Test plan
- MUL 7 × 0xFFFFFFF9... use op_a=7, op_b=0xFFFFFFFD → 0xFFFFFFEB. valid_o rises exactly 34 cycles after accept.
- MULH 0x80000000 × 0x80000000 → 0x40000000.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
- MULHSU op_a=0xFFFFFFFF, op_b=0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD; REM of the same operands → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- Divide by zero: DIVU 5/0 → 0xFFFFFFFF; REM 5/0 → 5. Overflow: DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same operands → 0. All four give valid_o one cycle after accept.
- Back-pressure and flush:
  - Hold ready_i low 10 cycles in DONE → valid_o and res_var stay stable.
  - Pulse kill_i in CALC cycle 5 → IDLE next cycle, no valid_o.
  - Assert rst_ni low in CALC → all outputs at reset values next edge.
  - Issue a new op after the kill → correct result.

Source files
------------

// File: rtl/cayde_muldiv_if.sv
// Request/result handshake bundle for the cayde iterative multiply/divide unit.
interface cayde_muldiv_if #(
  parameter int XLEN = 32
);
  logic            valid_i;
  logic            ready_o;
  logic [2:0]      op_i;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            kill_i;
  logic            valid_o;
  logic            ready_i;
  logic [XLEN-1:0] res_var;

  modport master (
    output valid_i, op_i, op_a, op_b, kill_i, ready_i,
    input  ready_o, valid_o, res_var
  );

  modport slave (
    input  valid_i, op_i, op_a, op_b, kill_i, ready_i,
    output ready_o, valid_o, res_var
  );
endinterface

// File: rtl/cayde_muldiv.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring-divide
// step per clock on operand magnitudes, sign fix-up in a single extra cycle,
// and a fast path for divide-by-zero and signed overflow.
//
// state | meaning
// IDLE  | ready for a request, operands latched on accept
// CALC  | XLEN multiply or divide iterations
// FIX   | sign correction and result select, res_var registered
// DONE  | result valid, held until the consumer takes it
module cayde_muldiv #(
  parameter int XLEN = 32
) (
  input logic          clk_i,
  input logic          rst_ni,
  cayde_muldiv_if.slave bus
);
  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [2:0] OP_MUL = 3'b000, OP_MULH = 3'b001, OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b100, OP_REM = 3'b110;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t            state, state_nxt;
  logic [2:0]        op_q;
  logic              neg_a, neg_b;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   quo;
  logic [CW-1:0]     cnt;
  logic [XLEN-1:0]   res_q;

  logic              accept, fast, div_zero, div_ovf;
  logic              neg_a_in, neg_b_in;
  logic [XLEN-1:0]   mag_a_in, mag_b_in, fast_res;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic [XLEN-1:0]   div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, res_fix;

  assign bus.ready_o = (state == IDLE);
  assign bus.valid_o = (state == DONE);
  assign bus.res_var = res_q;

  // Accept decode: operand signedness, magnitudes and the divide fast path.
  always_comb begin
    accept   = (state == IDLE) && bus.valid_i && !bus.kill_i;
    neg_a_in = ((bus.op_i == OP_MULH) || (bus.op_i == OP_MULHSU) ||
                (bus.op_i == OP_DIV)  || (bus.op_i == OP_REM)) && bus.op_a[XLEN-1];
    neg_b_in = ((bus.op_i == OP_MULH) || (bus.op_i == OP_DIV) ||
                (bus.op_i == OP_REM)) && bus.op_b[XLEN-1];
    mag_a_in = neg_a_in ? -bus.op_a : bus.op_a;
    mag_b_in = neg_b_in ? -bus.op_b : bus.op_b;
    div_zero = bus.op_i[2] && (bus.op_b == '0);
    div_ovf  = bus.op_i[2] && !bus.op_i[0] && (bus.op_a == MIN_VAL) && (bus.op_b == '1);
    fast     = div_zero || div_ovf;
    if (div_zero) fast_res = bus.op_i[1] ? bus.op_a : '1;
    else          fast_res = bus.op_i[1] ? '0 : bus.op_a;
  end

  // One iteration step and the final sign fix-up / result select.
  always_comb begin
    mul_sum   = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, mag_a} : '0);
    div_shift = {rem, quo[XLEN-1]};
    div_ge    = (div_shift >= {1'b0, mag_b});
    div_diff  = div_shift[XLEN-1:0] - mag_b;
    prod_fix  = (neg_a ^ neg_b) ? -prod : prod;
    quo_fix   = ((op_q == OP_DIV) && (neg_a ^ neg_b)) ? -quo : quo;
    rem_fix   = ((op_q == OP_REM) && neg_a) ? -rem : rem;
    case (op_q)
      OP_MUL:          res_fix = prod_fix[XLEN-1:0];
      3'b001, 3'b010,
      3'b011:          res_fix = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:  res_fix = quo_fix;
      default:         res_fix = rem_fix;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic; kill_i wins over every other condition.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = fast ? DONE : CALC;
      CALC:    if (cnt == CW'(XLEN-1)) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    if (bus.ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.kill_i) state_nxt = IDLE;
  end

  // Datapath: operand capture, iteration registers and result register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      op_q  <= '0;
      neg_a <= 1'b0;
      neg_b <= 1'b0;
      mag_a <= '0;
      mag_b <= '0;
      prod  <= '0;
      rem   <= '0;
      quo   <= '0;
      cnt   <= '0;
      res_q <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op_q  <= bus.op_i;
          neg_a <= neg_a_in;
          neg_b <= neg_b_in;
          mag_a <= mag_a_in;
          mag_b <= mag_b_in;
          prod  <= {{XLEN{1'b0}}, mag_b_in};
          rem   <= '0;
          quo   <= mag_a_in;
          cnt   <= '0;
          if (fast) res_q <= fast_res;
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          if (op_q[2]) begin
            rem <= div_ge ? div_diff : div_shift[XLEN-1:0];
            quo <= {quo[XLEN-2:0], div_ge};
          end else begin
            prod <= {mul_sum, prod[XLEN-1:1]};
          end
        end
        FIX: if (!bus.kill_i) res_q <= res_fix;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cayde_muldiv.sv
// Self-checking bench for cayde_muldiv: directed cases, back-pressure,
// kill/reset mid-operation and randomized ops against a 64-bit arithmetic model.
module tb_cayde_muldiv;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [31:0] last_res = '0;

  cayde_muldiv_if #(.XLEN(XLEN)) bus();
  cayde_muldiv #(.XLEN(XLEN)) dut (.clk_i(clk), .rst_ni(rst_ni), .bus(bus.slave));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub, p;
    int ia, ib;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    ia = a;
    ib = b;
    case (op)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
    return XLEN + 2;
  endfunction

  // Issue one request from a negedge; return at the negedge where valid_o is first seen.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    int w;
    w = 0;
    lat = 0;
    while (!bus.ready_o && w < 200) begin @(negedge clk); w++; end
    res = bus.res_var;
    if (!bus.ready_o) return;
    bus.valid_i = 1'b1;
    bus.op_i = op;
    bus.op_a = a;
    bus.op_b = b;
    @(posedge clk);
    @(negedge clk);
    lat = 1;
    bus.valid_i = 1'b0;
    bus.op_i = 3'($urandom);
    bus.op_a = $urandom;
    bus.op_b = $urandom;
    while (!bus.valid_o && lat < 100) begin @(negedge clk); lat++; end
    res = bus.res_var;
  endtask

  task automatic ack(input string tag);
    bus.ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.ready_i = 1'b0;
    chk({tag, "/idle_after_ack"}, {62'd0, bus.ready_o, bus.valid_o}, 64'd2);
  endtask

  task automatic check_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b);
    logic [31:0] res, exp;
    int lat;
    exp = ref_res(op, a, b);
    run_op(op, a, b, res, lat);
    chk({tag, "/res"}, res, exp);
    chk({tag, "/lat"}, lat, exp_lat(op, a, b));
    last_res = exp;
    ack(tag);
  endtask

  // Start an op and stop at the negedge of CALC cycle 5.
  task automatic start_and_wait5(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.valid_i = 1'b1;
    bus.op_i = op;
    bus.op_a = a;
    bus.op_b = b;
    @(posedge clk);
    @(negedge clk);
    bus.valid_i = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic watch_no_valid(input string tag);
    int seen;
    seen = 0;
    repeat (40) begin @(negedge clk); if (bus.valid_o) seen++; end
    chk(tag, seen, 0);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1);
  end

  initial begin
    logic [31:0] res, r0, a, b;
    logic [2:0] op;
    int lat;
    bus.valid_i = 1'b0;
    bus.kill_i  = 1'b0;
    bus.ready_i = 1'b0;
    bus.op_i    = '0;
    bus.op_a    = '0;
    bus.op_b    = '0;
    repeat (3) @(negedge clk);
    chk("reset/ready", bus.ready_o, 1);
    chk("reset/valid", bus.valid_o, 0);
    chk("reset/res", bus.res_var, 0);
    rst_ni = 1'b1;
    @(negedge clk);

    check_op("mul", 3'd0, 32'd7, 32'hFFFF_FFFD);
    check_op("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000);
    check_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check_op("div", 3'd4, 32'hFFFF_FFF9, 32'd2);
    check_op("rem", 3'd6, 32'hFFFF_FFF9, 32'd2);
    check_op("divu", 3'd5, 32'd100, 32'd7);
    check_op("remu", 3'd7, 32'd100, 32'd7);
    check_op("divu_by0", 3'd5, 32'd5, 32'd0);
    check_op("rem_by0", 3'd6, 32'd5, 32'd0);
    check_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    check_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF);

    run_op(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, r0, lat);
    chk("bp/res", r0, ref_res(3'd1, 32'h1234_5678, 32'h9ABC_DEF0));
    repeat (10) begin
      @(negedge clk);
      bus.op_a = $urandom;
      chk("bp/valid_held", bus.valid_o, 1);
      chk("bp/res_held", bus.res_var, r0);
    end
    bus.valid_i = 1'b1;
    bus.op_i = 3'd0;
    ack("bp");
    bus.valid_i = 1'b0;
    last_res = r0;

    start_and_wait5(3'd0, 32'd1234, 32'd5678);
    bus.kill_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.kill_i = 1'b0;
    chk("kill_calc/ready", bus.ready_o, 1);
    chk("kill_calc/valid", bus.valid_o, 0);
    chk("kill_calc/res_kept", bus.res_var, last_res);
    watch_no_valid("kill_calc/no_valid");
    check_op("after_kill", 3'd4, 32'hFFFF_FF9C, 32'd7);

    run_op(3'd5, 32'd1000, 32'd9, res, lat);
    bus.ready_i = 1'b1;
    bus.kill_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.kill_i = 1'b0;
    bus.ready_i = 1'b0;
    chk("kill_done/valid", bus.valid_o, 0);
    chk("kill_done/res_kept", bus.res_var, ref_res(3'd5, 32'd1000, 32'd9));

    bus.valid_i = 1'b1;
    bus.kill_i = 1'b1;
    bus.op_i = 3'd0;
    @(posedge clk);
    @(negedge clk);
    bus.valid_i = 1'b0;
    bus.kill_i = 1'b0;
    chk("kill_idle/ready", bus.ready_o, 1);
    watch_no_valid("kill_idle/no_valid");

    start_and_wait5(3'd6, 32'd99, 32'd4);
    rst_ni = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_calc/ready", bus.ready_o, 1);
    chk("rst_calc/valid", bus.valid_o, 0);
    chk("rst_calc/res", bus.res_var, 0);
    rst_ni = 1'b1;
    watch_no_valid("rst_calc/no_valid");
    check_op("after_rst", 3'd3, 32'hDEAD_BEEF, 32'hCAFE_F00D);

    for (int i = 0; i < 300; i++) begin
      op = 3'($urandom_range(0, 7));
      a = pick_operand();
      b = pick_operand();
      check_op($sformatf("rnd%0d_op%0d", i, op), op, a, b);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
